mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 255, maximum BUSY cycles before bus error; 8-bit range 1..255.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ALUResultM  in  WIDTH  byte address of the access, from the EX/MEM pipeline register.
REQ-006 WriteDataM  in  WIDTH  store data, unshifted.
REQ-007 MemWriteM  in  1  store request.
REQ-008 ResultSrcM  in  2  value 2'b01 means load.
REQ-009 AddrModeM  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 mem_req  out  1  bus request, registered.
REQ-011 mem_we  out  1  bus write enable.
REQ-012 mem_addr  out  WIDTH  word-aligned address, {ALUResultM[31:2],2'b00}.
REQ-013 mem_wdata  out  WIDTH  lane-replicated store data.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_ack  in  1  bus completion, one-cycle pulse.
REQ-016 mem_rdata  in  WIDTH  read word, valid with mem_ack.
REQ-017 StallM  out  1  freeze IF/ID/EX and the EX/MEM register.
REQ-018 ReadDataM  out  WIDTH  extended load result, registered.
REQ-019 MisalignM  out  1  combinational misaligned-access flag.
REQ-020 BusErrM  out  1  registered timeout flag.

Function
REQ-021 The unit SHALL define access = MemWriteM | (ResultSrcM==2'b01); a store takes priority if both are asserted.
REQ-022 The unit SHALL define misaligned as follows: mode W with addr[1:0]!=0, or mode H/HU with addr[0]!=0.
REQ-023 The unit SHALL treat AddrModeM values 011, 110 and 111 as W.
REQ-024 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-025 In IDLE with access and not misaligned, StallM SHALL be 1 combinationally and the FSM SHALL move to BUSY, latching we, addr, be, wdata, mode and offset.
REQ-026 In IDLE with access and misaligned, MisalignM SHALL be 1, no bus request SHALL be issued, StallM SHALL be 0, and ReadDataM SHALL be unchanged.
REQ-027 In BUSY, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata/mem_be SHALL hold the latched values stable until mem_ack.
REQ-028 StallM SHALL be 1 throughout BUSY.
REQ-029 mem_ack SHALL be accepted from the first BUSY cycle, giving a minimum latency of IDLE->BUSY->DONE = 2 stall cycles.
REQ-030 On mem_ack in BUSY, the FSM SHALL move to DONE, mem_req SHALL fall, and ReadDataM SHALL be loaded on loads only.
REQ-031 In DONE, StallM SHALL be 0 for exactly one cycle, and the FSM SHALL return to IDLE without re-triggering on the same instruction.
REQ-032 mem_ack outside BUSY SHALL be ignored.
REQ-033 Store lanes: SB gives be=4'b0001<<offset and wdata={4{WriteDataM[7:0]}}.
REQ-034 Store lanes: SH gives be=4'b0011<<offset and wdata={2{WriteDataM[15:0]}}.
REQ-035 Store lanes: SW gives be=4'b1111 and wdata=WriteDataM.
REQ-036 Loads SHALL set be=4'b1111.
REQ-037 Load extraction SHALL take the byte/half at rdata>>(8*offset); B/H SHALL sign-extend, BU/HU SHALL zero-extend, and W SHALL pass rdata.
REQ-038 The watchdog SHALL be an 8-bit counter that clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-039 When the watchdog count reaches TIMEOUT, the FSM SHALL go to DONE, set BusErrM=1, and set ReadDataM=0 on loads.
REQ-040 BusErrM SHALL clear on the next access that enters BUSY.
REQ-041 ReadDataM SHALL hold its value until the next load completes.

Reset
REQ-042 When rst_n=0, the unit SHALL asynchronously force: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadDataM=0, BusErrM=0, watchdog=0.
REQ-043 Reset during BUSY SHALL drop mem_req immediately and abandon the access; a late mem_ack SHALL then be ignored.
REQ-044 After rst_n rises, the first access SHALL start from IDLE.

Verification
REQ-045 LW with addr 0x100 and ack on the first BUSY cycle, rdata=0xDEADBEEF -> StallM 1 for 2 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-046 LB with addr 0x103, rdata=0x80112233 -> ReadDataM=0xFFFFFF80; repeated as LBU -> ReadDataM=0x00000080.
REQ-047 SH with addr 0x102, WriteDataM=0x0000ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, held for 3 wait cycles until ack.
REQ-048 LW with addr 0x101 -> MisalignM=1, mem_req never asserted, StallM=0.
REQ-049 TIMEOUT=4 with no ack -> DONE after 4 BUSY cycles, BusErrM=1, ReadDataM=0.
REQ-050 rst_n low during BUSY, then ack -> mem_req=0 immediately, FSM IDLE, ack ignored, ReadDataM=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM pipeline stage and a single-beat memory bus.
// Drives byte lanes for stores, extends loads, and watches for a bus that never acks.
module mem_access_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       AddrModeM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             StallM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             MisalignM,
    output logic             BusErrM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

    state_t           state_q;
    logic             req_q, we_q, buserr_q, uns_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]       be_q;
    logic [1:0]       size_q, off_q;
    logic [7:0]       wd_q;

    logic             is_load, access, misaligned;
    logic [1:0]       size_d, off_d;
    logic [3:0]       be_d;
    logic [WIDTH-1:0] wdata_d, shifted, load_ext;
    logic [8:0]       wd_inc;

    assign is_load = (ResultSrcM == 2'b01);
    assign access  = MemWriteM | is_load;
    assign off_d   = ALUResultM[1:0];

    // Reserved encodings fall through to word accesses.
    always_comb begin
        case (AddrModeM)
            3'b000, 3'b100: size_d = SZ_B;
            3'b001, 3'b101: size_d = SZ_H;
            default:        size_d = SZ_W;
        endcase
    end

    assign misaligned = ((size_d == SZ_W) && (off_d != 2'b00)) ||
                        ((size_d == SZ_H) && off_d[0]);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        if (MemWriteM) begin
            case (size_d)
                SZ_B: begin
                    be_d    = 4'b0001 << off_d;
                    wdata_d = {4{WriteDataM[7:0]}};
                end
                SZ_H: begin
                    be_d    = 4'b0011 << off_d;
                    wdata_d = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = WriteDataM;
                end
            endcase
        end
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_B:    load_ext = uns_q ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_ext = uns_q ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    assign wd_inc = {1'b0, wd_q} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
            size_q   <= SZ_W;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
            wd_q     <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && !misaligned) begin
                        state_q  <= BUSY;
                        req_q    <= 1'b1;
                        we_q     <= MemWriteM;
                        addr_q   <= {ALUResultM[WIDTH-1:2], 2'b00};
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        size_q   <= size_d;
                        uns_q    <= AddrModeM[2];
                        off_q    <= off_d;
                        wd_q     <= 8'd0;
                        buserr_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        if (!we_q) rdata_q <= load_ext;
                    end else begin
                        wd_q <= wd_inc[7:0];
                        if (wd_inc == 9'(TIMEOUT)) begin
                            state_q  <= DONE;
                            req_q    <= 1'b0;
                            buserr_q <= 1'b1;
                            if (!we_q) rdata_q <= '0;
                        end
                    end
                end
                // The stalled instruction is still presented here; leave without re-arming.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rdata_q;
    assign BusErrM   = buserr_q;
    assign MisalignM = access & misaligned;
    assign StallM    = (state_q == BUSY) ||
                       ((state_q == IDLE) && access && !misaligned);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus/completion records,
// a negedge monitor checks bus fields while mem_req is high and the result when the stall drops.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
    logic        MemWriteM = 1'b0, mem_ack = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  AddrModeM = 3'b010;
    logic        mem_req, mem_we, StallM, MisalignM, BusErrM;
    logic [31:0] mem_addr, mem_wdata, ReadDataM;
    logic [3:0]  mem_be;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .AddrModeM(AddrModeM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .StallM(StallM), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          stall;
    } txn_t;

    txn_t sb[$];
    int   tests = 0, fails = 0;
    bit   mon_en = 1'b1;
    bit   prev_stall = 1'b0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (!rst_n || !mon_en) begin
            prev_stall = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (mem_req) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: mem_req high with no pending access");
                end else begin
                    chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, sb[0].be});
                    if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (StallM) stall_cnt++;
            else if (prev_stall) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: stall released with no pending access");
                end else begin
                    t = sb.pop_front();
                    chk("ReadDataM", ReadDataM, t.rd);
                    chk("BusErrM", {31'd0, BusErrM}, {31'd0, t.err});
                    chk("stall_cycles", stall_cnt, t.stall);
                    chk("req_low_done", {31'd0, mem_req}, 32'd0);
                    $display("[TB] done addr=%h we=%0d rd=%h err=%0d stalls=%0d",
                             t.addr, t.we, ReadDataM, BusErrM, stall_cnt);
                end
                stall_cnt = 0;
            end
            prev_stall = StallM;
        end
    end

    // delay<0 means the bus never acks.
    task automatic access(input logic we, input logic ld, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] mode, input int delay,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_stall);
        txn_t t;
        t.we = we; t.addr = {addr[31:2], 2'b00}; t.be = exp_be; t.wdata = exp_wd;
        t.rd = exp_rd; t.err = exp_err; t.stall = exp_stall;
        sb.push_back(t);
        MemWriteM  = we;
        ResultSrcM = ld ? 2'b01 : 2'b00;
        ALUResultM = addr;
        WriteDataM = wd;
        AddrModeM  = mode;
        @(posedge clk); #1;
        for (int c = 0; c < 300 && StallM; c++) begin
            mem_ack   = (c == delay);
            mem_rdata = rdata;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        chk("done_reached", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rd", ReadDataM, 32'd0);
        chk("rst_err", {31'd0, BusErrM}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     we ld addr          wdata         mode    dly rdata         be       exp_wd        exp_rd        err stalls
        access(0, 1, 32'h100, 32'h0,        3'b010, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 2);
        access(0, 1, 32'h103, 32'h0,        3'b000, 0, 32'h80112233, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 2);
        access(0, 1, 32'h103, 32'h0,        3'b100, 0, 32'h80112233, 4'b1111, 32'h0,        32'h00000080, 0, 2);
        access(1, 0, 32'h102, 32'h0000ABCD, 3'b001, 3, 32'h0,        4'b1100, 32'hABCDABCD, 32'h00000080, 0, 5);
        access(0, 1, 32'h102, 32'h0,        3'b001, 0, 32'h80011234, 4'b1111, 32'h0,        32'hFFFF8001, 0, 2);
        access(0, 1, 32'h102, 32'h0,        3'b101, 1, 32'h80011234, 4'b1111, 32'h0,        32'h00008001, 0, 3);
        access(1, 0, 32'h101, 32'h123456A5, 3'b000, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h00008001, 0, 2);
        access(1, 1, 32'h204, 32'hCAFEF00D, 3'b010, 1, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h00008001, 0, 3);
        access(0, 1, 32'h208, 32'h0,        3'b011, 0, 32'h11223344, 4'b1111, 32'h0,        32'h11223344, 0, 2);

        // Misaligned word and half loads, with a stray ack that must be ignored.
        ResultSrcM = 2'b01; AddrModeM = 3'b010; ALUResultM = 32'h101;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_flag", {31'd0, MisalignM}, 32'd1);
            chk("mis_stall", {31'd0, StallM}, 32'd0);
            chk("mis_req", {31'd0, mem_req}, 32'd0);
            chk("mis_rd", ReadDataM, 32'h11223344);
            $display("[TB] misaligned addr=%h mis=%0d stall=%0d req=%0d",
                     ALUResultM, MisalignM, StallM, mem_req);
            @(posedge clk); #1;
            if (i == 1) begin AddrModeM = 3'b001; ALUResultM = 32'h103; end
        end
        mem_ack = 1'b0; ResultSrcM = 2'b00;
        @(posedge clk); #1;

        access(0, 1, 32'h300, 32'h0,        3'b010, -1, 32'h0,       4'b1111, 32'h0,        32'h00000000, 1, 5);
        access(0, 1, 32'h100, 32'h0,        3'b010, 0, 32'h00005A5A, 4'b1111, 32'h0,        32'h00005A5A, 0, 2);

        // Reset in the middle of a load; the late ack must not land.
        mon_en = 1'b0;
        ResultSrcM = 2'b01; AddrModeM = 3'b010; ALUResultM = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rb_busy_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0; ResultSrcM = 2'b00;
        #1;
        chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rb_stall", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("ra_req", {31'd0, mem_req}, 32'd0);
        chk("ra_rd", ReadDataM, 32'd0);
        chk("ra_stall", {31'd0, StallM}, 32'd0);
        $display("[TB] reset-abort req=%0d rd=%h stall=%0d", mem_req, ReadDataM, StallM);
        @(posedge clk); #1;
        mon_en = 1'b1;

        access(0, 1, 32'h100, 32'h0,        3'b010, 0, 32'h0BADF00D, 4'b1111, 32'h0,        32'h0BADF00D, 0, 2);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
